// File: rtl/ttt_computer_mover_if.sv
// Computer-move interface between the tic-tac-toe controller and the computer opponent.
//   req      : controller -> mover, level, high while the computer holds the turn
//   board    : controller -> mover, 9 x 2-bit cell codes, pos1 = [1:0] .. pos9 = [17:16]
//   button   : mover -> controller, one-hot move, bit0 = pos1 .. bit8 = pos9
//   pc       : mover -> controller, single-cycle move strobe
//   move_idx : mover -> controller, last chosen cell 1..9 (0 = none)
//   no_move  : mover -> controller, board was full at pick time
//   busy     : mover -> controller, mover is not idle
interface ttt_computer_mover_if;
   logic        req;
   logic [17:0] board;
   logic [8:0]  button;
   logic        pc;
   logic [3:0]  move_idx;
   logic        no_move;
   logic        busy;

   // Mover side: produces the move.
   modport master (
      input  req,
      input  board,
      output button,
      output pc,
      output move_idx,
      output no_move,
      output busy
   );

   // Controller side: grants the turn and consumes the move.
   modport slave (
      output req,
      output board,
      input  button,
      input  pc,
      input  move_idx,
      input  no_move,
      input  busy
   );
endinterface

// File: rtl/ttt_computer_mover.sv
// Automatic tic-tac-toe computer opponent. On a granted turn it snapshots the board, scans the
// eight lines one per cycle for a winning move, then for a blocking move, then falls back to a
// fixed-priority free cell, and issues the chosen move as a one-cycle pc pulse.
// Ports:
//   clk     : game clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : computer-move interface (master side): req/board in; button/pc/move_idx/no_move/
//             busy out, all registered
module ttt_computer_mover #(
   parameter int unsigned THINK_CYCLES  = 0,
   parameter logic [1:0]  PLAYER_CODE   = 2'b01,
   parameter logic [1:0]  COMPUTER_CODE = 2'b10
) (
   input logic                  clk,
   input logic                  reset_n,
   ttt_computer_mover_if.master bus
);

   typedef enum logic [2:0] {
      StIdle, StScanWin, StScanBlock, StPick, StThink, StIssue, StWaitRel
   } state_e;

   localparam logic [3:0] ThinkLast   = (THINK_CYCLES == 0) ? 4'd0 : 4'(THINK_CYCLES - 1);
   localparam state_e     AfterSelect = (THINK_CYCLES != 0) ? StThink : StIssue;

   state_e      state_q, state_d;
   logic [17:0] snap_q, snap_d;
   logic [2:0]  line_q, line_d;
   logic [3:0]  think_q, think_d;
   logic [3:0]  target_q, target_d;
   logic [8:0]  button_q, button_d;
   logic        pc_q, pc_d;
   logic [3:0]  move_idx_q, move_idx_d;
   logic        no_move_q, no_move_d;
   logic        busy_q, busy_d;

   // Cell positions (1-based) of each line, packed {first, second, third}.
   function automatic logic [11:0] line_cells(input logic [2:0] l);
      case (l)
         3'd0:    return {4'd1, 4'd2, 4'd3};
         3'd1:    return {4'd4, 4'd5, 4'd6};
         3'd2:    return {4'd7, 4'd8, 4'd9};
         3'd3:    return {4'd1, 4'd4, 4'd7};
         3'd4:    return {4'd2, 4'd5, 4'd8};
         3'd5:    return {4'd3, 4'd6, 4'd9};
         3'd6:    return {4'd1, 4'd5, 4'd9};
         default: return {4'd3, 4'd5, 4'd7};
      endcase
   endfunction

   function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] pos);
      logic [4:0] base;
      base = {pos - 4'd1, 1'b0};
      return b[base +: 2];
   endfunction

   function automatic logic is_free(input logic [17:0] b, input logic [3:0] pos);
      return cell_code(b, pos) == 2'b00;
   endfunction

   // Line evaluation on the snapshot; code 2'b11 never equals either side's code.
   logic [11:0] cells;
   logic [3:0]  p0, p1, p2;
   logic [1:0]  c0, c1, c2, scan_code;
   logic        hit;
   logic [3:0]  hit_pos;

   always_comb begin
      cells     = line_cells(line_q);
      p0        = cells[11:8];
      p1        = cells[7:4];
      p2        = cells[3:0];
      c0        = cell_code(snap_q, p0);
      c1        = cell_code(snap_q, p1);
      c2        = cell_code(snap_q, p2);
      scan_code = (state_q == StScanWin) ? COMPUTER_CODE : PLAYER_CODE;
      hit       = 1'b1;
      hit_pos   = 4'd0;
      if (c0 == scan_code && c1 == scan_code && c2 == 2'b00) begin
         hit_pos = p2;
      end else if (c0 == scan_code && c2 == scan_code && c1 == 2'b00) begin
         hit_pos = p1;
      end else if (c1 == scan_code && c2 == scan_code && c0 == 2'b00) begin
         hit_pos = p0;
      end else begin
         hit = 1'b0;
      end
   end

   // Fallback preference: centre, corners, then edges.
   logic       pick_found;
   logic [3:0] pick_pos;

   always_comb begin
      pick_found = 1'b1;
      pick_pos   = 4'd0;
      if      (is_free(snap_q, 4'd5)) pick_pos = 4'd5;
      else if (is_free(snap_q, 4'd1)) pick_pos = 4'd1;
      else if (is_free(snap_q, 4'd3)) pick_pos = 4'd3;
      else if (is_free(snap_q, 4'd7)) pick_pos = 4'd7;
      else if (is_free(snap_q, 4'd9)) pick_pos = 4'd9;
      else if (is_free(snap_q, 4'd2)) pick_pos = 4'd2;
      else if (is_free(snap_q, 4'd4)) pick_pos = 4'd4;
      else if (is_free(snap_q, 4'd6)) pick_pos = 4'd6;
      else if (is_free(snap_q, 4'd8)) pick_pos = 4'd8;
      else                            pick_found = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      line_d     = line_q;
      think_d    = think_q;
      target_d   = target_q;
      move_idx_d = move_idx_q;
      no_move_d  = no_move_q;
      pc_d       = 1'b0;
      button_d   = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               snap_d     = bus.board;
               line_d     = 3'd0;
               move_idx_d = 4'd0;
               no_move_d  = 1'b0;
               state_d    = StScanWin;
            end
         end
         StScanWin, StScanBlock: begin
            if (!bus.req) begin
               state_d = StIdle;
            end else if (hit) begin
               target_d = hit_pos;
               think_d  = 4'd0;
               state_d  = AfterSelect;
            end else if (line_q == 3'd7) begin
               line_d  = 3'd0;
               state_d = (state_q == StScanWin) ? StScanBlock : StPick;
            end else begin
               line_d = line_q + 3'd1;
            end
         end
         StPick: begin
            if (!bus.req) begin
               state_d = StIdle;
            end else if (pick_found) begin
               target_d = pick_pos;
               think_d  = 4'd0;
               state_d  = AfterSelect;
            end else begin
               no_move_d = 1'b1;
               state_d   = StWaitRel;
            end
         end
         StThink: begin
            if (!bus.req) begin
               state_d = StIdle;
            end else if (think_q == ThinkLast) begin
               state_d = StIssue;
            end else begin
               think_d = think_q + 4'd1;
            end
         end
         StIssue: begin
            // First edge raises the strobe, second edge drops it; req is ignored here.
            if (!pc_q) begin
               pc_d       = 1'b1;
               button_d   = 9'b1 << (target_q - 4'd1);
               move_idx_d = target_q;
            end else begin
               state_d = StWaitRel;
            end
         end
         StWaitRel: begin
            if (!bus.req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         snap_q     <= '0;
         line_q     <= '0;
         think_q    <= '0;
         target_q   <= '0;
         button_q   <= '0;
         pc_q       <= 1'b0;
         move_idx_q <= '0;
         no_move_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         line_q     <= line_d;
         think_q    <= think_d;
         target_q   <= target_d;
         button_q   <= button_d;
         pc_q       <= pc_d;
         move_idx_q <= move_idx_d;
         no_move_q  <= no_move_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.button   = button_q;
   assign bus.pc       = pc_q;
   assign bus.move_idx = move_idx_q;
   assign bus.no_move  = no_move_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ttt_computer_mover.sv
// Bench for ttt_computer_mover: directed boards, expected moves queued per DUT, monitors
// compare each pc pulse against the queue head.
module tb_ttt_computer_mover;

   localparam logic [1:0] E = 2'b00;
   localparam logic [1:0] X = 2'b01;  // player
   localparam logic [1:0] O = 2'b10;  // computer
   localparam logic [1:0] K = 2'b11;  // occupied, neither side

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ttt_computer_mover_if bus0 ();
   ttt_computer_mover_if bus3 ();

   ttt_computer_mover #(.THINK_CYCLES(0)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   ttt_computer_mover #(.THINK_CYCLES(3)) dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3)
   );

   typedef struct {
      int         lat;
      logic [8:0] button;
      logic [3:0] idx;
   } exp_t;

   exp_t q0[$];
   exp_t q3[$];
   exp_t m0, m3;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   e0_0 = 0;
   int   e0_3 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
      end
   endtask

   function automatic logic [17:0] brd(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
      return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
   endfunction

   // Monitors: every pc pulse must match the oldest expected move.
   always @(negedge clk) begin
      if (bus0.pc === 1'b1) begin
         chk("pc0_expected", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            m0 = q0.pop_front();
            chk("latency0", cyc - e0_0, m0.lat);
            chk("button0", 32'(bus0.button), 32'(m0.button));
            chk("move_idx0", 32'(bus0.move_idx), 32'(m0.idx));
         end
      end
   end

   always @(negedge clk) begin
      if (bus3.pc === 1'b1) begin
         chk("pc3_expected", 32'(q3.size() != 0), 32'd1);
         if (q3.size() != 0) begin
            m3 = q3.pop_front();
            chk("latency3", cyc - e0_3, m3.lat);
            chk("button3", 32'(bus3.button), 32'(m3.button));
            chk("move_idx3", 32'(bus3.move_idx), 32'(m3.idx));
         end
      end
   end

   task automatic push0(input int lat, input logic [8:0] b, input logic [3:0] i);
      q0.push_back('{lat, b, i});
   endtask

   // Raise req with a board; returns #1 after edge E0.
   task automatic start(input int which, input logic [17:0] b);
      @(negedge clk);
      if (which == 0) begin
         bus0.req = 1'b1;
         bus0.board = b;
      end else begin
         bus3.req = 1'b1;
         bus3.board = b;
      end
      @(posedge clk);
      #1;
      if (which == 0) e0_0 = cyc;
      else e0_3 = cyc;
   endtask

   // Advance to #1 after edge En of the current dut0 request.
   task automatic goto_cycle(input int n);
      while (cyc - e0_0 < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic release_req(input int which);
      if (which == 0) begin
         chk("drained0", 32'(q0.size()), 32'd0);
         bus0.req = 1'b0;
      end else begin
         chk("drained3", 32'(q3.size()), 32'd0);
         bus3.req = 1'b0;
      end
      @(posedge clk);
      #1;
      if (which == 0) begin
         chk("busy0_released", 32'(bus0.busy), 32'd0);
         bus0.board = '0;
      end else begin
         chk("busy3_released", 32'(bus3.busy), 32'd0);
         bus3.board = '0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] s2, s3, full, s11;
      s2   = brd(O, O, E, X, X, E, E, E, E);
      s3   = brd(E, E, E, E, O, E, X, X, E);
      full = brd(X, O, X, X, O, O, O, X, X);
      s11  = brd(E, K, K, E, K, E, E, E, E);
      bus0.req = 1'b0;
      bus0.board = '0;
      bus3.req = 1'b0;
      bus3.board = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", 32'(bus0.pc), 32'd0);
      chk("rst_button", 32'(bus0.button), 32'd0);
      chk("rst_move_idx", 32'(bus0.move_idx), 32'd0);
      chk("rst_no_move", 32'(bus0.no_move), 32'd0);
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_busy3", 32'(bus3.busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Empty board: centre pick at cycle 18.
      push0(18, 9'b000010000, 4'd5);
      start(0, brd(E, E, E, E, E, E, E, E, E));
      goto_cycle(1);
      chk("s1_busy", 32'(bus0.busy), 32'd1);
      goto_cycle(22);
      chk("s1_busy_hold", 32'(bus0.busy), 32'd1);
      chk("s1_idx_hold", 32'(bus0.move_idx), 32'd5);
      chk("s1_button_low", 32'(bus0.button), 32'd0);
      release_req(0);

      // Win on line 0 beats block on line 1.
      push0(2, 9'b000000100, 4'd3);
      start(0, s2);
      goto_cycle(6);
      release_req(0);

      // Block on line 2.
      push0(12, 9'b100000000, 4'd9);
      start(0, s3);
      goto_cycle(16);
      release_req(0);

      // Code 11 cells are occupied and never form a win.
      push0(18, 9'b000000001, 4'd1);
      start(0, s11);
      goto_cycle(22);
      release_req(0);

      // Full board: no pulse, no_move after E17, busy until release.
      start(0, full);
      goto_cycle(16);
      chk("s4_no_move_early", 32'(bus0.no_move), 32'd0);
      goto_cycle(17);
      chk("s4_no_move", 32'(bus0.no_move), 32'd1);
      chk("s4_busy", 32'(bus0.busy), 32'd1);
      chk("s4_move_idx", 32'(bus0.move_idx), 32'd0);
      goto_cycle(30);
      chk("s4_busy_hold", 32'(bus0.busy), 32'd1);
      chk("s4_no_move_hold", 32'(bus0.no_move), 32'd1);
      release_req(0);

      // Abort by dropping req during block scan.
      start(0, s3);
      goto_cycle(10);
      bus0.req = 1'b0;
      goto_cycle(12);
      chk("s5_abort_busy", 32'(bus0.busy), 32'd0);
      chk("s5_abort_no_move", 32'(bus0.no_move), 32'd0);
      chk("s5_abort_pc", 32'(bus0.pc), 32'd0);
      goto_cycle(25);
      chk("s5_abort_drained", 32'(q0.size()), 32'd0);
      bus0.board = '0;

      // Asynchronous reset mid-scan.
      start(0, s3);
      goto_cycle(5);
      chk("s5_busy_before_rst", 32'(bus0.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("s5_rst_busy", 32'(bus0.busy), 32'd0);
      chk("s5_rst_pc", 32'(bus0.pc), 32'd0);
      chk("s5_rst_button", 32'(bus0.button), 32'd0);
      bus0.req = 1'b0;
      bus0.board = '0;
      @(negedge clk);
      reset_n = 1'b1;

      // Re-request after reset completes normally.
      push0(12, 9'b100000000, 4'd9);
      start(0, s3);
      goto_cycle(16);
      release_req(0);

      // THINK_CYCLES=3, board bus cleared after capture: snapshot still wins.
      q3.push_back('{5, 9'b000000100, 4'd3});
      start(1, s2);
      @(posedge clk);
      #1;
      bus3.board = '0;
      repeat (12) @(posedge clk);
      #1;
      chk("s6_busy", 32'(bus3.busy), 32'd1);
      chk("s6_idx_hold", 32'(bus3.move_idx), 32'd3);
      release_req(1);

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
